graph_scan_sequencer: RTL and testbench
=======================================

Name: graph_scan_sequencer

Overview:
Sequences the 1k x 8 graph sample ROM for the VGA graph drawer. On a start pulse it sweeps ROM addresses from a start address to an end address in fixed steps. Each sample byte is converted to a screen Y coordinate above a baseline. Each point is handed to the line plotter as a segment (x, y_prev, y_cur) over a valid/ready handshake, so the plotter can join consecutive points.

Parameters:
ADDR_START, 10'd0, first ROM address of the sweep
ADDR_END, 10'd1023, last ROM address allowed in the sweep (inclusive)
ADDR_STEP, 10'd10, address increment between samples; must be nonzero
X_ORIGIN, 10'd20, screen X of the first sample
Y_BASE, 10'd400, screen Y of graph baseline (sample value 0)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep when idle
rom_addr  output  10  address to the sample ROM (combinational ROM, data valid same cycle)
rom_data  input  8  sample byte from ROM
seg_valid  output  1  segment outputs valid
seg_ready  input  1  plotter accepts segment
seg_x  output  10  screen X of current point
seg_y_prev  output  10  screen Y of previous point (equals seg_y_cur on first point)
seg_y_cur  output  10  screen Y of current point
busy  output  1  high from accepted start until DONE exits
done  output  1  single-cycle pulse when sweep completes

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE, rom_addr=ADDR_START, seg_valid=0, seg_x=X_ORIGIN, seg_y_prev=Y_BASE, seg_y_cur=Y_BASE, busy=0, done=0.
  - Internal first-point flag=1; sample index=0.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 -> FETCH; busy=1; rom_addr=ADDR_START; index=0; first flag=1.
  - start is ignored in all other states.
- FETCH (1 cycle):
  - rom_data is sampled for the current rom_addr.
  - y = Y_BASE - rom_data, computed in 11 bits and saturated to 0 if negative.
  - seg_y_prev = y if first flag set, else the previous seg_y_cur. Then seg_y_cur = y.
  - seg_x = X_ORIGIN + index, truncated to 10 bits (wraps).
  - seg_valid=1; go to EMIT.
- EMIT:
  - Hold all seg_* outputs stable while seg_valid=1 and seg_ready=0.
  - On seg_valid and seg_ready in the same cycle: seg_valid=0 next cycle; first flag=0; index+1.
  - next_addr = rom_addr + ADDR_STEP, computed in 11 bits.
  - If next_addr > ADDR_END or next_addr > 1023, go to DONE. Otherwise rom_addr=next_addr and go to FETCH.
- DONE (1 cycle): done=1, busy=0 next; go to IDLE. rom_addr returns to ADDR_START.
- Latency:
  - start to first seg_valid = 2 cycles (IDLE->FETCH, FETCH->EMIT).
  - Per point = 2 cycles with seg_ready held high.
- Handshake: seg_ready may be high before seg_valid; no combinational path from seg_ready to seg_valid.
- Edge cases:
  - ADDR_START > ADDR_END is not checked: exactly one point is emitted, then DONE.
  - reset mid-sweep aborts at once to the reset values; no done pulse.
- Arithmetic: all additions use one guard bit; no wrap of rom_addr past 1023.

Test Plan:
- Reset while EMIT with seg_ready=0 -> next cycle seg_valid=0, busy=0, state IDLE, rom_addr=ADDR_START, no done pulse.
- ADDR_START=40, ADDR_END=90, STEP=50, Y_BASE=400, X_ORIGIN=20, seg_ready=1, ROM 40->49, 90->77:
  - Point 1: (x=20, y_prev=351, y_cur=351).
  - Point 2: (x=21, y_prev=351, y_cur=323).
  - done pulses 1 cycle after the second handshake; busy low after.
- Backpressure: same sweep with seg_ready low for 5 cycles on point 1 -> seg_x/seg_y_* stable all 5 cycles, rom_addr stays 40, then sweep completes normally.
- Saturation: Y_BASE=50, ROM 570->100 (START=END=570) -> y_cur=0, y_prev=0; one point then done.
- Start ignored while busy: pulse start during EMIT of point 1 -> the sweep is unaffected, only one done pulse occurs, and the point count is unchanged.
- End clamp: START=1000, END=1023, STEP=10 -> addresses 1000, 1010, 1020 only (1030 > 1023 -> DONE), x=20, 21, 22.

Source files
------------

// File: rtl/graph_scan_sequencer.sv
// Graph sample sequencer: sweeps the sample ROM and hands each point to the
// line plotter as a (x, y_prev, y_cur) segment over valid/ready.
module graph_scan_sequencer #(
  parameter logic [9:0] ADDR_START = 10'd0,
  parameter logic [9:0] ADDR_END   = 10'd1023,
  parameter logic [9:0] ADDR_STEP  = 10'd10,
  parameter logic [9:0] X_ORIGIN   = 10'd20,
  parameter logic [9:0] Y_BASE     = 10'd400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       seg_valid,
  input  logic       seg_ready,
  output logic [9:0] seg_x,
  output logic [9:0] seg_y_prev,
  output logic [9:0] seg_y_cur,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t     state, state_nx;
  logic [9:0] index, index_nx;
  logic       first, first_nx;
  logic [9:0] rom_addr_nx, seg_x_nx, seg_y_prev_nx, seg_y_cur_nx;
  logic       seg_valid_nx, busy_nx, done_nx;
  logic [9:0] y_sample;
  logic [10:0] next_addr;

  // Baseline minus sample, clamped at the top of the screen.
  function automatic logic [9:0] sample_to_y(input logic [9:0] base, input logic [7:0] d);
    logic [10:0] diff;
    diff = {1'b0, base} - {3'b000, d};
    return diff[10] ? 10'd0 : diff[9:0];
  endfunction

  assign y_sample  = sample_to_y(Y_BASE, rom_data);
  assign next_addr = {1'b0, rom_addr} + {1'b0, ADDR_STEP};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= ADDR_START;
      seg_valid  <= 1'b0;
      seg_x      <= X_ORIGIN;
      seg_y_prev <= Y_BASE;
      seg_y_cur  <= Y_BASE;
      busy       <= 1'b0;
      done       <= 1'b0;
      first      <= 1'b1;
      index      <= 10'd0;
    end else begin
      state      <= state_nx;
      rom_addr   <= rom_addr_nx;
      seg_valid  <= seg_valid_nx;
      seg_x      <= seg_x_nx;
      seg_y_prev <= seg_y_prev_nx;
      seg_y_cur  <= seg_y_cur_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      first      <= first_nx;
      index      <= index_nx;
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_nx      = state;
    rom_addr_nx   = rom_addr;
    seg_valid_nx  = seg_valid;
    seg_x_nx      = seg_x;
    seg_y_prev_nx = seg_y_prev;
    seg_y_cur_nx  = seg_y_cur;
    busy_nx       = busy;
    done_nx       = 1'b0;
    first_nx      = first;
    index_nx      = index;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = FETCH;
          busy_nx     = 1'b1;
          rom_addr_nx = ADDR_START;
          index_nx    = 10'd0;
          first_nx    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      FETCH: begin
        seg_y_prev_nx = first ? y_sample : seg_y_cur;
        seg_y_cur_nx  = y_sample;
        seg_x_nx      = X_ORIGIN + index;
        seg_valid_nx  = 1'b1;
        state_nx      = EMIT;
      end
      EMIT: begin
        if (seg_valid && seg_ready) begin
          seg_valid_nx = 1'b0;
          first_nx     = 1'b0;
          index_nx     = index + 10'd1;
          // Guard bit catches both the configured end and the 10-bit ceiling.
          if ((next_addr > {1'b0, ADDR_END}) || (next_addr > 11'd1023)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            rom_addr_nx = next_addr[9:0];
            state_nx    = FETCH;
          end
        end else begin
          state_nx = EMIT;
        end
      end
      DONE: begin
        busy_nx     = 1'b0;
        rom_addr_nx = ADDR_START;
        state_nx    = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        seg_valid_nx = 1'b0;
        busy_nx      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_graph_scan_sequencer.sv
// Scoreboard bench: three sequencer configurations share one clock; expected
// segments are queued when a sweep starts and popped on each handshake.
module tb_graph_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start      [3];
  logic       ready      [3];
  logic [9:0] rom_addr   [3];
  logic [7:0] rom_data   [3];
  logic       seg_valid  [3];
  logic [9:0] seg_x      [3];
  logic [9:0] seg_y_prev [3];
  logic [9:0] seg_y_cur  [3];
  logic       busy       [3];
  logic       done       [3];

  int p_start [3] = '{40, 570, 1000};
  int p_end   [3] = '{90, 570, 1023};
  int p_step  [3] = '{50, 10, 10};
  int p_yb    [3] = '{400, 50, 400};
  localparam int XO = 20;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hs_cnt   [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int last_hs  [3] = '{0, 0, 0};
  int cyc = 0;
  logic [39:0] exp_q [$];

  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    case (a)
      10'd40:  return 8'd49;
      10'd90:  return 8'd77;
      10'd570: return 8'd100;
      default: return a[7:0] ^ 8'h5a;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_rom
    assign rom_data[g] = rom_fn(rom_addr[g]);
  end

  graph_scan_sequencer #(.ADDR_START(10'd40), .ADDR_END(10'd90), .ADDR_STEP(10'd50),
                         .X_ORIGIN(10'd20), .Y_BASE(10'd400)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .seg_valid(seg_valid[0]), .seg_ready(ready[0]), .seg_x(seg_x[0]), .seg_y_prev(seg_y_prev[0]),
    .seg_y_cur(seg_y_cur[0]), .busy(busy[0]), .done(done[0]));

  graph_scan_sequencer #(.ADDR_START(10'd570), .ADDR_END(10'd570), .ADDR_STEP(10'd10),
                         .X_ORIGIN(10'd20), .Y_BASE(10'd50)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .seg_valid(seg_valid[1]), .seg_ready(ready[1]), .seg_x(seg_x[1]), .seg_y_prev(seg_y_prev[1]),
    .seg_y_cur(seg_y_cur[1]), .busy(busy[1]), .done(done[1]));

  graph_scan_sequencer #(.ADDR_START(10'd1000), .ADDR_END(10'd1023), .ADDR_STEP(10'd10),
                         .X_ORIGIN(10'd20), .Y_BASE(10'd400)) dut_c (
    .clk(clk), .reset(reset), .start(start[2]), .rom_addr(rom_addr[2]), .rom_data(rom_data[2]),
    .seg_valid(seg_valid[2]), .seg_ready(ready[2]), .seg_x(seg_x[2]), .seg_y_prev(seg_y_prev[2]),
    .seg_y_cur(seg_y_cur[2]), .busy(busy[2]), .done(done[2]));

  task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of one sweep: queue {addr, x, y_prev, y_cur} per point.
  task automatic push_sweep(input int i, output int n);
    int a, y, prev;
    bit first;
    a = p_start[i]; first = 1'b1; prev = 0; n = 0;
    forever begin
      y = p_yb[i] - int'(rom_fn(10'(a)));
      if (y < 0) y = 0;
      exp_q.push_back({10'(a), 10'(XO + n), 10'(first ? y : prev), 10'(y)});
      prev = y; first = 1'b0; n++;
      if ((a + p_step[i] > p_end[i]) || (a + p_step[i] > 1023)) break;
      a = a + p_step[i];
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake and done monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && seg_valid[i] && ready[i]) begin
        hs_cnt[i]++;
        last_hs[i] = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexpected_seg", {rom_addr[i], seg_x[i], seg_y_prev[i], seg_y_cur[i]}, 40'd0);
        end else begin
          check_val("segment", {rom_addr[i], seg_x[i], seg_y_prev[i], seg_y_cur[i]}, exp_q.pop_front());
        end
      end
      if (!reset && done[i]) begin
        done_cnt[i]++;
        check_val("done_after_hs", 40'(cyc), 40'(last_hs[i] + 1));
        check_val("busy_in_done", 40'(busy[i]), 40'd1);
      end
    end
  end

  task automatic run_sweep(input int i, input int hold, input bit restart, input bit rnd);
    int n, d0, h0;
    logic [39:0] snap;
    bit fin;
    push_sweep(i, n);
    d0 = done_cnt[i]; h0 = hs_cnt[i];
    ready[i] = (hold == 0);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    @(negedge clk);
    check_val("lat_fetch_valid", 40'(seg_valid[i]), 40'd0);
    check_val("busy_after_start", 40'(busy[i]), 40'd1);
    @(negedge clk);
    check_val("lat_emit_valid", 40'(seg_valid[i]), 40'd1);
    snap = {rom_addr[i], seg_x[i], seg_y_prev[i], seg_y_cur[i]};
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1 start[i] = restart && (k == 1);
      @(negedge clk);
      check_val("hold_stable", {rom_addr[i], seg_x[i], seg_y_prev[i], seg_y_cur[i]}, snap);
      check_val("hold_valid", 40'(seg_valid[i]), 40'd1);
    end
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      start[i] = 1'b0;
      ready[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fin = (done_cnt[i] != d0);
    end
    repeat (10) @(negedge clk);
    check_val("done_count", 40'(done_cnt[i] - d0), 40'd1);
    check_val("point_count", 40'(hs_cnt[i] - h0), 40'(n));
    check_val("busy_after_done", 40'(busy[i]), 40'd0);
    check_val("idle_valid", 40'(seg_valid[i]), 40'd0);
    check_val("idle_addr", 40'(rom_addr[i]), 40'(p_start[i]));
    check_val("queue_empty", 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, h0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; ready[i] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_valid", 40'(seg_valid[i]), 40'd0);
      check_val("rst_busy_done", {busy[i], done[i]}, 40'd0);
      check_val("rst_addr", 40'(rom_addr[i]), 40'(p_start[i]));
      check_val("rst_seg", {seg_x[i], seg_y_prev[i], seg_y_cur[i]},
                {10'(XO), 10'(p_yb[i]), 10'(p_yb[i])});
    end
    @(posedge clk); #1 reset = 1'b0;

    run_sweep(0, 0, 1'b0, 1'b0);   // basic two-point sweep
    run_sweep(0, 5, 1'b0, 1'b0);   // backpressure on point 1
    run_sweep(0, 3, 1'b1, 1'b0);   // start pulse while busy
    run_sweep(0, 0, 1'b0, 1'b1);   // random ready

    // Abort from EMIT with the plotter stalled.
    d0 = done_cnt[0]; h0 = hs_cnt[0];
    ready[0] = 1'b0;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_val("emit_before_reset", 40'(seg_valid[0]), 40'd1);
    @(negedge clk);
    check_val("abort_valid", 40'(seg_valid[0]), 40'd0);
    check_val("abort_busy_done", {busy[0], done[0]}, 40'd0);
    check_val("abort_addr", 40'(rom_addr[0]), 40'd40);
    check_val("abort_seg", {seg_x[0], seg_y_prev[0], seg_y_cur[0]}, {10'd20, 10'd400, 10'd400});
    @(posedge clk); #1 reset = 1'b0; ready[0] = 1'b1;
    repeat (10) @(negedge clk);
    check_val("abort_no_done", 40'(done_cnt[0] - d0), 40'd0);
    check_val("abort_no_seg", 40'(hs_cnt[0] - h0), 40'd0);

    run_sweep(1, 0, 1'b0, 1'b0);   // saturation to y=0
    run_sweep(2, 0, 1'b0, 1'b0);   // end clamp at 1023
    run_sweep(2, 2, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
